ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; its ports SHALL be named clk and rst.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on the rising edge.
REQ-005 alu_func  input  5  ALU function code from decode; only ALU_MUL, ALU_DIV and ALU_REM (sys_defs.vh) are accepted.
REQ-006 funct3  input  3  RISC-V M variant: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 opa  input  32  rs1 operand (multiplicand or dividend).
REQ-008 opb  input  32  rs2 operand (multiplier or divisor).
REQ-009 flush  input  1  synchronous abort of any operation in flight.
REQ-010 busy  output  1  high while an operation is in flight.
REQ-011 done  output  1  single-cycle pulse; result is valid in that cycle.
REQ-012 result  output  32  operation result.

Function
REQ-013 The state machine SHALL have the states IDLE, CALC, FIX and DONE.
REQ-014 IDLE->CALC on an edge with start=1, flush=0 and alu_func in {ALU_MUL, ALU_DIV, ALU_REM}; operands, funct3 and sign flags SHALL be latched on that edge.
REQ-015 In IDLE, start with any other alu_func SHALL be ignored; the block stays in IDLE.
REQ-016 start SHALL be ignored while busy=1; no queuing.
REQ-017 CALC SHALL run exactly 32 iterations, one per clock, using a 5-bit counter: radix-2 shift-add for multiply and restoring shift-subtract for divide.
REQ-018 Each iteration SHALL operate on operand magnitudes.
REQ-019 Signedness: MUL and MULH treat both operands as signed; MULHSU treats opa as signed and opb as unsigned; MULHU, DIVU and REMU treat both as unsigned; DIV and REM treat both as signed.
REQ-020 CALC->FIX after the 32nd iteration.
REQ-021 FIX SHALL apply sign correction and special cases, then go to DONE.
REQ-022 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the full 64-bit signed-corrected product.
REQ-023 The DIV quotient SHALL be negated if the operand signs differ; the REM remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = opa, for both signed and unsigned variants.
REQ-025 Signed overflow (opa=0x80000000, opb=0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000 and remainder 0.
REQ-026 In DONE, done=1 for exactly one cycle; the next state is IDLE.
REQ-027 Latency SHALL be fixed and data-independent: done is high in the 34th cycle after the accepting edge (CALC 32 cycles, FIX 1 cycle, DONE 1 cycle).
REQ-028 busy SHALL be 1 in CALC, FIX and DONE, and 0 in IDLE.
REQ-029 result SHALL be updated only on the FIX->DONE edge and SHALL hold its value until the next completed operation.
REQ-030 flush=1 in any state SHALL force IDLE on the next edge, suppress done and leave result unchanged.
REQ-031 When flush and start are both 1 on the same edge, flush SHALL win and the request SHALL be dropped.
REQ-032 A new start SHALL be accepted in the first IDLE cycle after DONE, giving a back-to-back issue rate of one operation per 35 cycles.

Reset
REQ-033 While rst=1, independent of clk, the block SHALL hold: state=IDLE, counter=0, busy=0, done=0, result=0x00000000, internal accumulators=0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation immediately; no done pulse SHALL follow reset release.
REQ-035 The first start after reset release SHALL be accepted on the first clock edge.

Verification
REQ-036 MUL opa=7, opb=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 34 cycles after the accepting edge; busy high throughout.
REQ-037 opa=opb=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
REQ-038 DIV opa=0xFFFFFFF9 (-7), opb=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-039 DIVU opa=5, opb=0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-040 Start a DIV, assert flush in CALC iteration 10 -> busy=0 on the next edge, no done, result unchanged; a start on the following edge is accepted and completes normally.
REQ-041 Assert rst asynchronously between edges mid-CALC -> busy, done and result read 0 before the next edge; start held at 1 during busy is ignored, and alu_func=ALU_ADD with start=1 leaves the block in IDLE.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// One operation at a time with a fixed latency of 34 cycles from the accepting
// edge to the done pulse. Multiply is radix-2 shift-add, divide is restoring
// shift-subtract; both run on operand magnitudes and the sign is fixed up at
// the end.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     request to begin an operation
//   alu_func  decode function code; only MUL/DIV/REM codes start the unit
//   funct3    M-extension variant (MUL..REMU)
//   opa, opb  rs1 / rs2 operands
//   flush     synchronous abort, returns to IDLE without a done pulse
//   busy      high while an operation is in flight
//   done      one-cycle pulse, result valid in that cycle
//   result    last completed result, held until the next completion
//
// state | meaning
// IDLE  | waiting for an accepted start
// CALC  | 32 shift-add / shift-subtract iterations
// FIX   | sign correction and divide special cases
// DONE  | result registered, done pulsed
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  alu_func,
  input  logic [2:0]  funct3,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [4:0] ALU_MUL = 5'h0A;
  localparam logic [4:0] ALU_DIV = 5'h0B;
  localparam logic [4:0] ALU_REM = 5'h0C;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [31:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [31:0] result_q, result_d;

  logic        func_ok, signed_a, signed_b, in_neg_a, in_neg_b;
  logic [32:0] sum33, sh33, diff33;
  logic        res_neg, div_zero, div_ovf;
  logic [63:0] prod64;
  logic [31:0] quo_fix, rem_fix, opa_back, fix_val;

  assign func_ok  = (alu_func == ALU_MUL) || (alu_func == ALU_DIV) || (alu_func == ALU_REM);
  // Unsigned variants are 011 MULHU, 101 DIVU, 111 REMU; opb is also unsigned for MULHSU.
  assign signed_a = ~(funct3[0] & (funct3[1] | funct3[2]));
  assign signed_b = signed_a & (funct3 != 3'b010);
  assign in_neg_a = signed_a & opa[31];
  assign in_neg_b = signed_b & opb[31];

  // Multiply step: acc_hi:acc_lo holds partial product : remaining multiplier bits.
  assign sum33  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : 33'd0);
  // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign sh33   = {acc_hi_q, acc_lo_q[31]};
  assign diff33 = sh33 - {1'b0, mag_b_q};

  assign res_neg  = neg_a_q ^ neg_b_q;
  assign prod64   = res_neg ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quo_fix  = res_neg ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_a_q ? -acc_hi_q : acc_hi_q;
  assign opa_back = neg_a_q ? -mag_a_q : mag_a_q;
  assign div_zero = (mag_b_q == 32'd0);
  assign div_ovf  = neg_a_q & neg_b_q & (mag_a_q == 32'h8000_0000) & (mag_b_q == 32'd1);

  always_comb begin
    fix_val = prod64[31:0];
    case (f3_q)
      3'b000:                 fix_val = prod64[31:0];
      3'b001, 3'b010, 3'b011: fix_val = prod64[63:32];
      3'b100, 3'b101:         fix_val = div_zero ? 32'hFFFF_FFFF :
                                        div_ovf  ? 32'h8000_0000 : quo_fix;
      default:                fix_val = div_zero ? opa_back :
                                        div_ovf  ? 32'd0 : rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && func_ok) begin
          state_d  = CALC;
          cnt_d    = 5'd31;
          f3_d     = funct3;
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          mag_a_d  = in_neg_a ? -opa : opa;
          mag_b_d  = in_neg_b ? -opb : opb;
          acc_hi_d = 32'd0;
          acc_lo_d = funct3[2] ? (in_neg_a ? -opa : opa) : (in_neg_b ? -opb : opb);
        end
      end
      CALC: begin
        if (f3_q[2]) begin
          if (!diff33[32]) begin
            acc_hi_d = diff33[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = sh33[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          acc_hi_d = sum33[32:1];
          acc_lo_d = {sum33[0], acc_lo_q[31:1]};
        end
        if (cnt_q == 5'd0) state_d = FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      FIX: begin
        result_d = fix_val;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      f3_q     <= 3'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  // A flush arriving in DONE still swallows the pulse.
  assign done   = (state_q == DONE) & ~flush;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  localparam logic [4:0] ALU_ADD = 5'h00;
  localparam logic [4:0] ALU_MUL = 5'h0A;
  localparam logic [4:0] ALU_DIV = 5'h0B;
  localparam logic [4:0] ALU_REM = 5'h0C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  alu_func = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_result = 32'd0;

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .alu_func(alu_func), .funct3(funct3),
    .opa(opa), .opb(opb), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the M-extension definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ubs;
    logic [63:0] ua, ub, p;
    int ia, ib;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ubs = {32'd0, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    case (f3)
      3'd0: begin p = ua * ub;   return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ubs;  return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    logic [31:0] exp;
    int n, w, busy_ok, res_ok;
    exp = ref_model(f3, a, b);
    w = 0;
    while (busy && w < 40) begin @(posedge clk); #1; w++; end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    alu_func = f3[2] ? (f3[1] ? ALU_REM : ALU_DIV) : ALU_MUL;
    funct3 = f3; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin opa = $urandom; opb = $urandom; funct3 = 3'($urandom); end
    else start = 1'b0;
    n = 1; busy_ok = 1; res_ok = 1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 0;
      if (result !== last_result) res_ok = 0;
      @(posedge clk); #1; n++;
    end
    if (!busy) busy_ok = 0;
    start = 1'b0;
    check({tag, "_busy"}, busy_ok, 32'd1);
    check({tag, "_hold"}, res_ok, 32'd1);
    check({tag, "_lat"}, n, 32'd34);
    check({tag, "_res"}, result, exp);
    last_result = exp;
  endtask

  initial begin
    int nd;
    logic [31:0] ra, rb;
    logic [31:0] pick [5];
    #1 rst = 1'b1;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", result, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;

    do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    check("mul_7_m3_val", last_result, 32'hFFFF_FFEB);
    do_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
    do_op("divu_5_0", 3'd5, 32'd5, 32'd0, 0);
    do_op("remu_5_0", 3'd7, 32'd5, 32'd0, 0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("div_m9_0", 3'd4, 32'hFFFF_FFF7, 32'd0, 0);
    do_op("rem_m9_0", 3'd6, 32'hFFFF_FFF7, 32'd0, 0);
    do_op("hold_start", 3'd4, 32'd1000, 32'hFFFF_FFFD, 1);

    // Flush in CALC iteration 10, then a start on the very next edge.
    alu_func = ALU_DIV; funct3 = 3'd4; opa = 32'd12345; opb = 32'd17; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_res", result, last_result);
    do_op("after_flush", 3'd5, 32'd12345, 32'd17, 0);

    // Flush and start together: the request is dropped.
    alu_func = ALU_MUL; funct3 = 3'd0; opa = 32'd3; opb = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("flush_start", {31'd0, busy}, 32'd0);

    pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF; pick[3] = 32'h8000_0000;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      pick[4] = $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) ra = pick[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = pick[$urandom_range(0, 4)];
      do_op("rand", 3'($urandom_range(0, 7)), ra, rb, 0);
    end

    do_op("pre_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    alu_func = ALU_MUL; funct3 = 3'd0; opa = 32'd99; opb = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_res", result, 32'd0);
    last_result = 32'd0;
    @(posedge clk); #3 rst = 1'b0;
    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) nd++; end
    check("no_done_after_rst", nd, 32'd0);

    alu_func = ALU_ADD; start = 1'b1;
    nd = 0;
    repeat (3) begin @(posedge clk); #1; if (busy) nd++; end
    start = 1'b0;
    check("alu_add_ignored", nd, 32'd0);
    do_op("final", 3'd6, 32'd100, 32'hFFFF_FFF9, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
